gcd_job_ctrl: RTL and testbench

Job sequencer between the AXI register front end and the wide GCD core. It accepts one operand pair per job and latches it onto the core argument bus. It pulses the core start, supervises the run with a cycle counter and optional watchdog, then captures the results into a holding register. The results are presented on a valid/ready response channel with an error flag and an interrupt pulse. One job is in flight at a time.

---
 rtl/gcd_pkg.sv | 15 +
 rtl/gcd_run_counter.sv | 37 +++
 rtl/gcd_job_ctrl.sv | 161 ++++++++++++++++
 tb/tb_gcd_job_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and widths for the GCD job controller and its helpers.
package gcd_pkg;

  localparam int unsigned GCD_ARG_W = 1279;
  localparam int unsigned GCD_RES_W = 1284;
  localparam int unsigned GCD_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    RESP   = 2'd3
  } gcd_state_e;

endpackage

// File: rtl/gcd_run_counter.sv
// Saturating run-cycle counter with synchronous clear/enable and a flag that
// marks the last cycle before LIMIT is reached (count == LIMIT-1).
module gcd_run_counter #(
  parameter int unsigned W     = 32,
  parameter int unsigned LIMIT = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         at_limit_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o    = count_q;
  assign at_limit_o = (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/gcd_job_ctrl.sv
// One-job-at-a-time sequencer around the wide GCD core: latch args, start,
// supervise, capture, respond. Watchdog enabled by GCD_JOB_CTRL_TIMEOUT_EN.
module gcd_job_ctrl
  import gcd_pkg::*;
#(
  parameter int unsigned ARG_W   = GCD_ARG_W,
  parameter int unsigned RES_W   = GCD_RES_W,
  parameter int unsigned CNT_W   = GCD_CNT_W,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [ARG_W-1:0] REQ_ARG_A,
  input  logic [ARG_W-1:0] REQ_ARG_B,
  input  logic             ABORT,
  output logic [ARG_W-1:0] CORE_ARG_A,
  output logic [ARG_W-1:0] CORE_ARG_B,
  output logic             CORE_START,
  input  logic             CORE_DONE,
  input  logic [RES_W-1:0] CORE_RESULT_A,
  input  logic [RES_W-1:0] CORE_RESULT_B,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [RES_W-1:0] RSP_RESULT_A,
  output logic [RES_W-1:0] RSP_RESULT_B,
  output logic             RSP_ERR,
  output logic             BUSY,
  output logic [CNT_W-1:0] CYCLES,
  output logic             IRQ
);

  gcd_state_e       state_q, state_d;
  logic [ARG_W-1:0] arg_a_q, arg_a_d, arg_b_q, arg_b_d;
  logic [RES_W-1:0] res_a_q, res_a_d, res_b_q, res_b_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             start_q, start_d;
  logic             irq_q, irq_d;
  logic             abort_pend_q, abort_pend_d;
  logic             cnt_clr, cnt_en, at_limit, timeout;
  logic [CNT_W-1:0] cycles;

  gcd_run_counter #(
    .W     (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_run_counter (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .count_o    (cycles),
    .at_limit_o (at_limit)
  );

`ifdef GCD_JOB_CTRL_TIMEOUT_EN
  assign timeout = at_limit;
`else
  logic unused_at_limit;
  assign unused_at_limit = at_limit;
  assign timeout         = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    arg_a_d      = arg_a_q;
    arg_b_d      = arg_b_q;
    res_a_d      = res_a_q;
    res_b_d      = res_b_q;
    err_d        = err_q;
    valid_d      = valid_q;
    start_d      = 1'b0;
    irq_d        = 1'b0;
    abort_pend_d = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          arg_a_d = REQ_ARG_A;
          arg_b_d = REQ_ARG_B;
          err_d   = 1'b0;
          cnt_clr = 1'b1;
          start_d = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        // An abort seen while launching is honoured in the first RUN cycle.
        abort_pend_d = ABORT;
        state_d      = RUN;
      end
      RUN: begin
        // A watchdog exit reports the count it tripped on, not one past it.
        cnt_en = CORE_DONE || !timeout;
        if (CORE_DONE) begin
          res_a_d = CORE_RESULT_A;
          res_b_d = CORE_RESULT_B;
          err_d   = 1'b0;
          valid_d = 1'b1;
          irq_d   = 1'b1;
          state_d = RESP;
        end else if (ABORT || abort_pend_q || timeout) begin
          res_a_d = '0;
          res_b_d = '0;
          err_d   = 1'b1;
          valid_d = 1'b1;
          irq_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      arg_a_q      <= '0;
      arg_b_q      <= '0;
      res_a_q      <= '0;
      res_b_q      <= '0;
      err_q        <= 1'b0;
      valid_q      <= 1'b0;
      start_q      <= 1'b0;
      irq_q        <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      arg_a_q      <= arg_a_d;
      arg_b_q      <= arg_b_d;
      res_a_q      <= res_a_d;
      res_b_q      <= res_b_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
      start_q      <= start_d;
      irq_q        <= irq_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign REQ_READY    = (state_q == IDLE);
  assign BUSY         = (state_q != IDLE);
  assign CORE_ARG_A   = arg_a_q;
  assign CORE_ARG_B   = arg_b_q;
  assign CORE_START   = start_q;
  assign RSP_VALID    = valid_q;
  assign RSP_RESULT_A = res_a_q;
  assign RSP_RESULT_B = res_b_q;
  assign RSP_ERR      = err_q;
  assign CYCLES       = cycles;
  assign IRQ          = irq_q;

endmodule

// File: tb/tb_gcd_job_ctrl.sv
// Self-checking bench for gcd_job_ctrl: directed job table, hand-written
// corner sequences and random jobs against a job-level reference model.
module tb_gcd_job_ctrl;
  import gcd_pkg::*;

  localparam int unsigned AW = GCD_ARG_W;
  localparam int unsigned RW = GCD_RES_W;
  localparam int unsigned CW = GCD_CNT_W;
  localparam int unsigned TO = 20;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic [AW-1:0] REQ_ARG_A = '0;
  logic [AW-1:0] REQ_ARG_B = '0;
  logic          ABORT = 1'b0;
  logic [AW-1:0] CORE_ARG_A, CORE_ARG_B;
  logic          CORE_START;
  logic          CORE_DONE = 1'b0;
  logic [RW-1:0] CORE_RESULT_A = '0;
  logic [RW-1:0] CORE_RESULT_B = '0;
  logic          RSP_VALID;
  logic          RSP_READY = 1'b0;
  logic [RW-1:0] RSP_RESULT_A, RSP_RESULT_B;
  logic          RSP_ERR, BUSY, IRQ;
  logic [CW-1:0] CYCLES;

  int checks = 0;
  int errors = 0;

  gcd_job_ctrl #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ARG_A(REQ_ARG_A), .REQ_ARG_B(REQ_ARG_B), .ABORT(ABORT),
    .CORE_ARG_A(CORE_ARG_A), .CORE_ARG_B(CORE_ARG_B), .CORE_START(CORE_START),
    .CORE_DONE(CORE_DONE), .CORE_RESULT_A(CORE_RESULT_A), .CORE_RESULT_B(CORE_RESULT_B),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RESULT_A(RSP_RESULT_A), .RSP_RESULT_B(RSP_RESULT_B), .RSP_ERR(RSP_ERR),
    .BUSY(BUSY), .CYCLES(CYCLES), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned lat;          // RUN cycle carrying CORE_DONE, 0 = never
    int unsigned abort_at;     // RUN cycle carrying ABORT, 0 = never
    bit          abort_launch; // ABORT already high during LAUNCH
    int unsigned rsp_wait;     // cycles of RSP_READY=0 backpressure
    bit          exp_err;
    int unsigned exp_a;
    int unsigned exp_b;
    int unsigned exp_cycles;
  } vec_t;

  function automatic int unsigned gcd_ref(input int unsigned a, input int unsigned b);
    int unsigned x = a;
    int unsigned y = b;
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Job-level outcome: earliest of DONE/ABORT wins, DONE on a tie.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int unsigned g = gcd_ref(v.a, v.b);
    if (v.lat != 0 && (v.abort_at == 0 || v.lat <= v.abort_at)) begin
      r.exp_err = 1'b0; r.exp_a = g; r.exp_b = v.a / g; r.exp_cycles = v.lat;
    end else begin
      r.exp_err = 1'b1; r.exp_a = 0; r.exp_b = 0; r.exp_cycles = v.abort_at;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chkw(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act[63:0], exp[63:0], $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic start_job(input int unsigned a, input int unsigned b, input bit abort_launch);
    int n = 0;
    while (!REQ_READY && n < 50) begin
      tick();
      n++;
    end
    chk1("req_ready_idle", REQ_READY, 1'b1);
    REQ_VALID = 1'b1;
    REQ_ARG_A = AW'(a);
    REQ_ARG_B = AW'(b);
    CORE_DONE = 1'b1;  // stale DONE level through IDLE and LAUNCH
    CORE_RESULT_A = RW'($urandom);
    CORE_RESULT_B = RW'($urandom);
    tick();
    REQ_VALID = 1'b0;
    REQ_ARG_A = AW'($urandom);
    REQ_ARG_B = AW'($urandom);
    chk1("launch_start", CORE_START, 1'b1);
    chk1("launch_busy", BUSY, 1'b1);
    chk1("launch_req_ready", REQ_READY, 1'b0);
    chkw("launch_arg_a", RW'(CORE_ARG_A), RW'(a));
    chkw("launch_arg_b", RW'(CORE_ARG_B), RW'(b));
    chkw("launch_cycles", RW'(CYCLES), RW'(0));
    chk1("launch_err_clr", RSP_ERR, 1'b0);
    ABORT = abort_launch;
    tick();
    chk1("run_start_low", CORE_START, 1'b0);
    chk1("run_no_valid", RSP_VALID, 1'b0);
    chkw("run_arg_a_hold", RW'(CORE_ARG_A), RW'(a));
  endtask

  task automatic run_phase(input vec_t v, output bit exited);
    int unsigned g = gcd_ref(v.a, v.b);
    exited = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      CORE_DONE     = (v.lat == k);
      CORE_RESULT_A = CORE_DONE ? RW'(g) : RW'($urandom);
      CORE_RESULT_B = CORE_DONE ? RW'(v.a / g) : RW'($urandom);
      ABORT         = (v.abort_at == k) || (v.abort_launch && k == 1);
      tick();
      if (RSP_VALID) begin
        exited = 1'b1;
        break;
      end
      chkw("run_cycles", RW'(CYCLES), RW'(k));
      chk1("run_busy", BUSY, 1'b1);
    end
    CORE_DONE = 1'b0;
    ABORT     = 1'b0;
    chk1("run_exit", exited, 1'b1);
  endtask

  task automatic resp_phase(input vec_t v);
    chk1("resp_valid", RSP_VALID, 1'b1);
    chk1("resp_irq", IRQ, 1'b1);
    chk1("resp_req_ready", REQ_READY, 1'b0);
    chk1("resp_err", RSP_ERR, v.exp_err);
    chkw("resp_res_a", RSP_RESULT_A, RW'(v.exp_a));
    chkw("resp_res_b", RSP_RESULT_B, RW'(v.exp_b));
    chkw("resp_cycles", RW'(CYCLES), RW'(v.exp_cycles));
    for (int i = 0; i < int'(v.rsp_wait); i++) begin
      CORE_DONE = 1'b1;
      ABORT     = 1'b1;
      REQ_VALID = 1'b1;
      CORE_RESULT_A = RW'($urandom);
      tick();
      chk1("hold_irq_low", IRQ, 1'b0);
      chk1("hold_valid", RSP_VALID, 1'b1);
      chk1("hold_req_ready", REQ_READY, 1'b0);
      chk1("hold_err", RSP_ERR, v.exp_err);
      chkw("hold_res_a", RSP_RESULT_A, RW'(v.exp_a));
      chkw("hold_cycles", RW'(CYCLES), RW'(v.exp_cycles));
    end
    CORE_DONE = 1'b0;
    ABORT     = 1'b0;
    REQ_VALID = 1'b0;
    RSP_READY = 1'b1;
    tick();
    RSP_READY = 1'b0;
    chk1("done_valid_low", RSP_VALID, 1'b0);
    chk1("done_req_ready", REQ_READY, 1'b1);
    chk1("done_busy_low", BUSY, 1'b0);
    chk1("done_irq_low", IRQ, 1'b0);
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    bit ex;
    start_job(v.a, v.b, v.abort_launch);
    run_phase(v, ex);
    if (ex) resp_phase(v);
    else apply_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vecs [0:6];
    vec_t v;
    bit   ex;
    //        a    b  lat ab  al wt err  A  B  cyc
    vecs[0] = '{48,  18, 10, 0, 0, 0, 0, 6, 8, 10};
    vecs[1] = '{100, 75, 7,  0, 0, 5, 0, 25, 4, 7};
    vecs[2] = '{48,  18, 0,  3, 0, 1, 1, 0, 0, 3};
    vecs[3] = '{48,  18, 5,  5, 0, 0, 0, 6, 8, 5};
    vecs[4] = '{12,  8,  0,  0, 1, 2, 1, 0, 0, 1};
    vecs[5] = '{9,   6,  1,  0, 0, 0, 0, 3, 3, 1};
    vecs[6] = '{20,  5,  8,  2, 0, 3, 1, 0, 0, 2};

    // Reset state
    tick();
    tick();
    chk1("rst_req_ready", REQ_READY, 1'b1);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_valid", RSP_VALID, 1'b0);
    chk1("rst_start", CORE_START, 1'b0);
    chk1("rst_irq", IRQ, 1'b0);
    chk1("rst_err", RSP_ERR, 1'b0);
    chkw("rst_cycles", RW'(CYCLES), RW'(0));
    chkw("rst_arg_a", RW'(CORE_ARG_A), RW'(0));
    chkw("rst_res_a", RSP_RESULT_A, RW'(0));
    RESET = 1'b0;
    tick();

    // Stray DONE/ABORT while idle
    CORE_DONE = 1'b1;
    ABORT     = 1'b1;
    CORE_RESULT_A = RW'(123);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("stray_busy", BUSY, 1'b0);
      chk1("stray_valid", RSP_VALID, 1'b0);
      chk1("stray_irq", IRQ, 1'b0);
      chk1("stray_start", CORE_START, 1'b0);
    end
    CORE_DONE = 1'b0;
    ABORT     = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset in the 4th RUN cycle drops the job without a response
    start_job(99, 33, 1'b0);
    tick();
    tick();
    tick();
    RESET = 1'b1;
    #1;
    chk1("mid_rst_busy", BUSY, 1'b0);
    chk1("mid_rst_req_ready", REQ_READY, 1'b1);
    chk1("mid_rst_valid", RSP_VALID, 1'b0);
    chkw("mid_rst_cycles", RW'(CYCLES), RW'(0));
    chkw("mid_rst_arg_a", RW'(CORE_ARG_A), RW'(0));
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("post_rst_irq", IRQ, 1'b0);
      chk1("post_rst_valid", RSP_VALID, 1'b0);
      chk1("post_rst_busy", BUSY, 1'b0);
    end
    v = '{35, 14, 6, 0, 0, 1, 0, 7, 5, 6};
    run_vec(v);

    // Watchdog: DONE never arrives
    start_job(1000, 10, 1'b0);
`ifdef GCD_JOB_CTRL_TIMEOUT_EN
    v = '{1000, 10, 0, 0, 0, 2, 1, 0, 0, TO - 1};
`else
    v = '{1000, 10, 0, 101, 0, 0, 1, 0, 0, 101};
`endif
    run_phase(v, ex);
    if (ex) resp_phase(v);
    else apply_reset();

    // Random jobs against the job-level model
    for (int n = 0; n < 25; n++) begin
      int unsigned g = $urandom_range(1, 40);
      v.a            = g * $urandom_range(1, 100);
      v.b            = g * $urandom_range(1, 100);
      v.lat          = $urandom_range(1, 15);
      v.abort_at     = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 15) : 0;
      v.abort_launch = 1'b0;
      v.rsp_wait     = $urandom_range(0, 3);
      v = model(v);
      run_vec(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
